// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants: default widths, control-field layout and
// the default flush mask used by every pipe_stage_reg instance.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CTRL_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control-field layout for the default 16-bit control word.
  localparam int unsigned CTRL_OP_LSB    = 0;
  localparam int unsigned CTRL_OP_W      = 7;
  localparam int unsigned CTRL_RD_LSB    = 7;
  localparam int unsigned CTRL_RD_W      = 5;
  localparam int unsigned CTRL_FLAGS_LSB = 12;
  localparam int unsigned CTRL_FLAGS_W   = 4;

  typedef struct packed {
    logic [CTRL_FLAGS_W-1:0] flags;
    logic [CTRL_RD_W-1:0]    rd;
    logic [CTRL_OP_W-1:0]    op;
  } ctrl_t;

  // Wide all-ones source; instances truncate it to their CTRL_W (CTRL_W <= 64).
  localparam logic [63:0] CLR_MASK_DEF = '1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter.
// Ports: clk, rst_n (async active-low), en_i (count this cycle),
//        cnt_o (registered count, sticks at all ones).
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: increment when enabled, hold at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush and stall count.
// Ports: clk, reset (async active-low);
//        in_valid/in_ready/in_data/in_ctrl   - upstream handshake and payload;
//        out_valid/out_ready/out_data/out_ctrl - downstream handshake, registered;
//        flush     - squash both held beats and any beat accepted this cycle;
//        stall_cnt - saturating count of cycles with out_valid && !out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CLR_MASK = CTRL_W'(CLR_MASK_DEF),
  parameter int unsigned       CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              in_ready_q,   in_ready_d;

  logic accept_c;
  logic emit_c;

  assign accept_c = in_valid && in_ready_q;
  assign emit_c   = main_valid_q && out_ready;

  // Next-state for main/skid entries and the registered ready.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      // Payload is left in place; only the masked control bits are squashed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = main_ctrl_q & ~CLR_MASK;
    end else if (!main_valid_q || emit_c) begin
      if (skid_valid_q) begin
        // in_ready was low, so nothing can be accepted alongside a skid drain.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept_c;
        if (accept_c) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign in_ready  = in_ready_q;

  // Back-pressure counter; flush does not clear it.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (main_valid_q && !out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  c;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [15:0]  in_ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [15:0]  out_ctrl;
  logic         flush = 1'b0;
  logic [15:0]  stall_cnt;

  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [127:0] s_in_data = '0;
  logic [15:0]  s_in_ctrl = '0;
  logic         s_out_valid;
  logic         s_out_ready = 1'b0;
  logic [127:0] s_out_data;
  logic [15:0]  s_out_ctrl;
  logic         s_flush = 1'b0;
  logic [3:0]   s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(
    .CNT_W    (4),
    .CLR_MASK (16'h00FF)
  ) u_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_ctrl   (s_in_ctrl),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_ctrl  (s_out_ctrl),
    .flush     (s_flush),
    .stall_cnt (s_stall_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the default instance: an ordered list of at
  // most two held beats, plus the last payload shown on the output.
  beat_t        mq[$];
  logic         m_rdy  = 1'b0;
  logic [15:0]  m_cnt  = '0;
  logic [127:0] m_data = '0;
  logic [15:0]  m_ctrl = '0;

  task automatic model_step();
    logic acc;
    logic emt;
    beat_t b;
    if (!reset) begin
      mq.delete();
      m_rdy  = 1'b0;
      m_cnt  = '0;
      m_data = '0;
      m_ctrl = '0;
    end else begin
      acc = in_valid && m_rdy;
      emt = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
      if (flush) begin
        mq.delete();
        m_ctrl = m_ctrl & ~16'hFFFF;
      end else begin
        if (emt) b = mq.pop_front();
        if (acc) begin
          b.d = in_data;
          b.c = in_ctrl;
          mq.push_back(b);
        end
        if (mq.size() > 0) begin
          m_data = mq[0].d;
          m_ctrl = mq[0].c;
        end
      end
      m_rdy = (mq.size() < 2);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      model_step();
    end
  end

  // Emission log of the default instance, with cycle stamps.
  int          cyc = 0;
  logic [15:0] seen[$];
  int          seen_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("in_ready",  128'(in_ready),  128'(m_rdy));
    chk("out_data",  out_data,        m_data);
    chk("out_ctrl",  128'(out_ctrl),  128'(m_ctrl));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
    if (reset && out_valid && out_ready) begin
      seen.push_back(out_data[15:0]);
      seen_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_seq(input string name, input logic [15:0] base, input int n);
    chk({name, "_len"}, 128'(seen.size()), 128'(n));
    for (int i = 0; i < n && i < seen.size(); i++) begin
      chk({name, "_beat"}, 128'(seen[i]), 128'(base + 16'(i)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    chk("rst_out_data",  out_data,        128'(0));
    chk("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_stall",     128'(stall_cnt), 128'(0));
    reset = 1'b1;
    #1;
    chk("rel_in_ready_pre", 128'(in_ready), 128'(0));
    tick();
    chk("rel_in_ready_post", 128'(in_ready), 128'(1));

    // Streaming 8 beats with out_ready high.
    seen.delete(); seen_cyc.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(i);
      in_ctrl  = 16'(i);
      tick();
      if (i == 1) begin
        chk("lat_out_valid", 128'(out_valid), 128'(1));
        chk("lat_out_data",  out_data,        128'(1));
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk_seq("stream", 16'h1, 8);
    for (int i = 1; i < seen_cyc.size(); i++) begin
      chk("stream_gap", 128'(seen_cyc[i] - seen_cyc[i-1]), 128'(1));
    end

    // Back-pressure: out_ready low for four cycles mid-stream.
    seen.delete(); seen_cyc.delete();
    begin
      int idx = 0;
      logic rdy_now;
      for (int c = 0; c < 20; c++) begin
        in_valid  = (idx < 8);
        in_data   = 128'(16'h11 + 16'(idx));
        in_ctrl   = 16'h11 + 16'(idx);
        out_ready = !(c >= 2 && c < 6);
        rdy_now   = in_ready;
        tick();
        if (in_valid && rdy_now) idx++;
        if (c == 3) chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("bp_stall_cnt", 128'(stall_cnt), 128'(4));
    chk_seq("bp", 16'h11, 8);

    // Flush with both entries full and a beat waiting upstream.
    seen.delete(); seen_cyc.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 128'(16'hA1); in_ctrl = 16'hF0A1;
    tick();
    in_data = 128'(16'hA2); in_ctrl = 16'hF0A2;
    tick();
    chk("fl_full_in_ready", 128'(in_ready), 128'(0));
    in_data = 128'(16'hA3); in_ctrl = 16'hF0A3;
    flush = 1'b1;
    tick();
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("fl_in_ready",  128'(in_ready),  128'(1));
    chk("fl_out_data",  out_data,        128'(16'hA1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_none_emitted", 128'(seen.size()), 128'(0));

    // Flush drops a beat accepted in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 128'(16'hB1); in_ctrl = 16'h00B1;
    tick();
    in_data = 128'(16'hB2); in_ctrl = 16'h00B2;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("fl2_none_emitted", 128'(seen.size()), 128'(0));
    in_valid = 1'b1; in_data = 128'(16'hC1); in_ctrl = 16'h00C1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk_seq("post_flush", 16'hC1, 1);

    // Reset pulse with the skid entry full.
    seen.delete(); seen_cyc.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 128'(16'hD1); in_ctrl = 16'h00D1;
    tick();
    in_data = 128'(16'hD2); in_ctrl = 16'h00D2;
    tick();
    in_data = 128'(16'hD3); in_ctrl = 16'h00D3;
    reset = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(out_valid), 128'(0));
    chk("mrst_in_ready",  128'(in_ready),  128'(0));
    chk("mrst_stall",     128'(stall_cnt), 128'(0));
    repeat (2) tick();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("mrst_none_emitted", 128'(seen.size()), 128'(0));
    chk("mrst_in_ready_rel", 128'(in_ready), 128'(1));

    // Saturation and partial flush mask on the CNT_W=4 instance.
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 128'(5); s_in_ctrl = 16'hABCD;
    tick();
    s_in_valid = 1'b0;
    repeat (14) tick();
    chk("sat_cnt_14", 128'(s_stall_cnt), 128'(14));
    repeat (6) tick();
    chk("sat_cnt_hold", 128'(s_stall_cnt), 128'(15));
    chk("sat_out_ctrl", 128'(s_out_ctrl),  128'(16'hABCD));
    chk("sat_out_valid", 128'(s_out_valid), 128'(1));
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    chk("sat_fl_ctrl",  128'(s_out_ctrl),  128'(16'hAB00));
    chk("sat_fl_valid", 128'(s_out_valid), 128'(0));
    chk("sat_fl_data",  s_out_data,        128'(5));
    chk("sat_fl_cnt",   128'(s_stall_cnt), 128'(15));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, datapath payload width (e.g. four 32-bit operands).
REQ-002 SHALL have parameter CTRL_W, default 16, control-field width.
REQ-003 SHALL have parameter CLR_MASK, CTRL_W bits, default all ones; marks control bits zeroed on flush.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, upstream beat present.
REQ-008 SHALL have port in_ready, output, 1, stage can accept a beat.
REQ-009 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W, upstream control fields.
REQ-011 SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts beat.
REQ-013 SHALL have port out_data, output, DATA_W, registered payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W, registered control fields.
REQ-015 SHALL have port flush, input, 1, squash all held beats (branch/exception).
REQ-016 SHALL have port stall_cnt, output, CNT_W, saturating count of back-pressured cycles.

Function
REQ-017 SHALL hold two entries: main (drives out_*) and skid; each with a valid flag.
REQ-018 SHALL accept a beat when in_valid && in_ready; SHALL emit when out_valid && out_ready.
REQ-019 SHALL drive out_valid = main valid; out_data/out_ctrl = main contents, registered.
REQ-020 SHALL drive in_ready from a register; next value = skid empty after the current edge.
REQ-021 SHALL load main when main empty or emitting: from skid if skid valid, else from accepted input.
REQ-022 SHALL write an accepted beat into skid only when main full and not emitting.
REQ-023 SHALL give 1-cycle latency in to out when empty; full throughput (one beat/cycle) with out_ready held high.
REQ-024 SHALL preserve beat order; no beat lost or duplicated except by flush.
REQ-025 SHALL, on flush high at an edge, clear both valid flags, AND out_ctrl with ~CLR_MASK, leave out_data unchanged, drop any beat accepted that cycle, set in_ready to 1.
REQ-026 SHALL give flush priority over accept and emit in the same cycle.
REQ-027 SHALL hold main contents stable while out_valid && !out_ready.
REQ-028 SHALL increment stall_cnt each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1; flush does not clear it.
REQ-029 SHALL, when in_valid with skid full, not accept (in_ready 0); input is upstream's to hold.

Reset
REQ-030 SHALL, while reset low, asynchronously force out_valid 0, in_ready 0, out_data 0, out_ctrl 0, stall_cnt 0, both valid flags 0.
REQ-031 SHALL raise in_ready at the first rising clk edge after reset deasserts.
REQ-032 SHALL, on reset mid-transfer, discard all held beats; no beat emitted after release until newly accepted.

Structure
REQ-033 SHALL take control-field layout constants (field offsets/widths, default CLR_MASK) from shared package pipe_pkg.
REQ-034 SHALL instantiate one sub-module, pipe_sat_counter (parametrised CNT_W, enable, async active-low reset), for stall_cnt.
REQ-035 SHALL be instantiable per stage (IF/ID, ID/EX, EX/MEM, MEM/WB) by parameter only.

Verification
REQ-036 SHALL cover reset release: reset low 3 cycles -> all outputs 0; in_ready 1 one edge after release.
REQ-037 SHALL cover streaming: 8 beats 0x1..0x8, out_ready high -> outputs in order, first at edge+1, no gaps.
REQ-038 SHALL cover back-pressure: out_ready low 4 cycles during stream -> skid takes one beat, in_ready falls, stall_cnt=4, order intact after release.
REQ-039 SHALL cover flush with both entries full and in_valid high -> next edge out_valid 0, out_ctrl bits in CLR_MASK 0, in_ready 1, flushed beats never appear.
REQ-040 SHALL cover saturation: CNT_W=4, 20 stalled cycles -> stall_cnt holds 15.
REQ-041 SHALL cover mid-stream reset pulse with skid full -> out_valid 0 immediately, no stale beat after release.
